sevenseg_scan_driver: RTL
=========================

Name: sevenseg_scan_driver

Overview:
- Time-multiplexed driver for a bank of NUM_DIGITS common-anode 7-segment digits sharing one segment bus.
- Generalises the single-digit hex-to-segment decode:
  - full 0-F glyph set, with an alternative decimal mode;
  - per-digit decimal points;
  - leading-zero suppression and global blanking;
  - tear-free value updates committed only at frame boundaries.
- Sits between datapath/counter logic and the board's seg/an/dp pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 100000, clk cycles each digit stays selected; legal range >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- value_in  input  4*NUM_DIGITS  display value; nibble k drives digit k, with digit 0 the rightmost/LSB.
- load  input  1  one-cycle strobe; captures value_in and dp_in for display.
- dp_in  input  NUM_DIGITS  per-digit decimal point request, 1 = lit.
- hex_mode  input  1  1 = nibbles A-F shown as hex glyphs; 0 = nibbles >9 shown as dash.
- lz_suppress  input  1  1 = blank leading zero digits.
- blank  input  1  1 = all digits dark (an all 1).
- seg  output  [0:6]  segments a..g, seg[0]=a; active-low (0 = on).
- dp  output  1  decimal point, active-low.
- an  output  NUM_DIGITS  digit enables, active-low, one-hot-low when active.
- digit_idx  output  3  index of the digit currently being scanned.
- frame_tick  output  1  one-cycle pulse when the scan wraps from NUM_DIGITS-1 to 0.

Behaviour:
- Reset (rst_n=0 at clk edge) sets:
  - seg=7'b111_1111, dp=1, an=all 1, digit_idx=0, frame_tick=0;
  - divider=0, display and pending registers=0, pending_valid=0.
- Divider:
  - counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1 it returns to 0 and digit_idx advances, wrapping NUM_DIGITS-1 -> 0.
- frame_tick:
  - asserted exactly in the cycle after digit_idx becomes 0 via wrap;
  - never asserted out of reset.
- Load/commit:
  - load=1 copies value_in/dp_in to pending and sets pending_valid.
  - A second load before commit overwrites pending (last wins).
  - Commit happens on the clk edge where digit_idx wraps to 0: display <= pending, pending_valid cleared.
  - If load coincides with that edge, value_in/dp_in are committed directly and pending_valid ends at 0.
  - Display contents never change mid-frame.
- Glyphs (seg a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
  - In decimal mode, nibbles 10-15 show dash 1111110.
- Leading-zero suppression:
  - Scanning from digit NUM_DIGITS-1 down, each digit whose nibble is 0 and all of whose higher digits are 0 shows seg=1111111.
  - Digit 0 is never suppressed.
  - dp on a suppressed digit still follows dp_in.
- Outputs are registered:
  - seg/dp/an reflect the current digit_idx and display register with 1-cycle latency.
  - In the cycle where divider==0 (first cycle of each slot), an=all 1 (anti-ghost guard).
  - Otherwise an[digit_idx]=0 and all other bits are 1.
- blank=1 forces an=all 1 on the next cycle; scanning, divider and commit continue unaffected.
- hex_mode and lz_suppress are sampled live, not latched with load.
- Reset mid-frame discards pending and display data; the scan restarts at digit 0.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4 unless noted):
- Reset held 3 cycles, then released:
  - seg=1111111, an=1111, digit_idx=0 while reset is held;
  - first frame_tick at cycle 16 after release;
  - an sequence 1111,1110,1110,1110,1111,1101,... as the scan starts.
- load value_in=16'h12AF, hex_mode=1, dp_in=4'b0010:
  - after the next frame_tick, digit slots show F=0111000, A=0001000 (dp=0), 2=0010010, 1=1001111.
  - No change is visible before the wrap.
- hex_mode=0, display 16'h00A5:
  - digit0=5 (0100100), digit1=dash (1111110), digits 2-3 show 0000001.
- lz_suppress=1, display 16'h0040:
  - digits 3 and 2 blank (1111111), digit1=4 (1001100), digit0=0 (0000001).
  - Display 16'h0000: only digit0 is lit.
- Two loads, 16'h1111 then 16'h2222, in the same frame:
  - only 2222 appears at the next frame; 1111 is never displayed.
  - A load on the wrap edge is committed immediately.
- blank=1 for one full frame:
  - an=1111 throughout; frame_tick period is unchanged.
  - Deasserting blank restores normal scanning on the next cycle.

Source files
------------

// File: rtl/sevenseg_scan_driver.sv
// Multiplexed common-anode 7-segment scanner: per-slot divider, frame-synchronous
// display commit, hex/decimal glyphs, leading-zero suppression and blanking.
module sevenseg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    hex_mode,
  input  logic                    lz_suppress,
  input  logic                    blank,
  output logic [0:6]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [2:0]              digit_idx,
  output logic                    frame_tick
);

  localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [2:0]       IDX_LAST = 3'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]      r_div;
  logic [2:0]            r_idx;
  logic                  r_frame_tick;
  logic [0:6]            r_seg;
  logic                  r_dp;
  logic [NUM_DIGITS-1:0] r_an;
  logic [VAL_W-1:0]      r_disp_val;
  logic [NUM_DIGITS-1:0] r_disp_dp;
  logic [VAL_W-1:0]      r_pend_val;
  logic [NUM_DIGITS-1:0] r_pend_dp;
  logic                  r_pend_vld;

  logic                  w_slot_end;
  logic                  w_wrap;
  logic [DIV_W-1:0]      w_div_nxt;
  logic [2:0]            w_idx_nxt;
  logic [VAL_W-1:0]      w_disp_val_nxt;
  logic [NUM_DIGITS-1:0] w_disp_dp_nxt;
  logic [3:0]            w_nib;
  logic                  w_dig_dp;
  logic                  w_zero_run;
  logic                  w_lz_blank;
  logic [0:6]            w_seg_nxt;
  logic [NUM_DIGITS-1:0] w_an_nxt;

  function automatic logic [0:6] f_glyph(input logic [3:0] nib, input logic hex);
    logic [0:6] g;
    case (nib)
      4'h0:    g = 7'b0000001;
      4'h1:    g = 7'b1001111;
      4'h2:    g = 7'b0010010;
      4'h3:    g = 7'b0000110;
      4'h4:    g = 7'b1001100;
      4'h5:    g = 7'b0100100;
      4'h6:    g = 7'b0100000;
      4'h7:    g = 7'b0001111;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0000100;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b1100000;
      4'hC:    g = 7'b0110001;
      4'hD:    g = 7'b1000010;
      4'hE:    g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    if (!hex && nib > 4'd9) g = 7'b1111110;
    return g;
  endfunction

  // Outputs are computed from next-state values so they line up with digit_idx.
  always_comb begin
    w_slot_end     = (r_div == DIV_LAST);
    w_wrap         = w_slot_end && (r_idx == IDX_LAST);
    w_div_nxt      = w_slot_end ? '0 : r_div + DIV_W'(1);
    w_idx_nxt      = w_wrap ? 3'd0 : (w_slot_end ? r_idx + 3'd1 : r_idx);
    w_disp_val_nxt = r_disp_val;
    w_disp_dp_nxt  = r_disp_dp;
    if (w_wrap) begin
      if (load) begin
        w_disp_val_nxt = value_in;
        w_disp_dp_nxt  = dp_in;
      end else if (r_pend_vld) begin
        w_disp_val_nxt = r_pend_val;
        w_disp_dp_nxt  = r_pend_dp;
      end
    end

    w_nib      = 4'h0;
    w_dig_dp   = 1'b0;
    w_zero_run = 1'b1;
    w_lz_blank = 1'b0;
    w_an_nxt   = '1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run && (w_disp_val_nxt[4*k +: 4] == 4'h0);
      if (3'(k) == w_idx_nxt) begin
        w_nib      = w_disp_val_nxt[4*k +: 4];
        w_dig_dp   = w_disp_dp_nxt[k];
        w_lz_blank = lz_suppress && w_zero_run && (k != 0);
        w_an_nxt[k] = blank || (w_div_nxt == '0);
      end
    end
    w_seg_nxt = w_lz_blank ? 7'b1111111 : f_glyph(w_nib, hex_mode);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div        <= '0;
      r_idx        <= 3'd0;
      r_frame_tick <= 1'b0;
      r_seg        <= 7'b1111111;
      r_dp         <= 1'b1;
      r_an         <= '1;
      r_disp_val   <= '0;
      r_disp_dp    <= '0;
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_pend_vld   <= 1'b0;
    end else begin
      r_div        <= w_div_nxt;
      r_idx        <= w_idx_nxt;
      r_frame_tick <= w_wrap;
      r_seg        <= w_seg_nxt;
      r_dp         <= ~w_dig_dp;
      r_an         <= w_an_nxt;
      r_disp_val   <= w_disp_val_nxt;
      r_disp_dp    <= w_disp_dp_nxt;
      if (load) begin
        r_pend_val <= value_in;
        r_pend_dp  <= dp_in;
        r_pend_vld <= !w_wrap;
      end else if (w_wrap) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign digit_idx  = r_idx;
  assign frame_tick = r_frame_tick;

endmodule
